// File: rtl/multi_data_queue.sv
// rtl/multi_data_queue.sv - in-order variable-latency request queue
// Each entry counts down its own delay; only the head may complete, so results leave in acceptance order.
module multi_data_queue #(
   parameter int WIDTH      = 32,
   parameter int DELAY_BITS = 2,
   parameter int DEPTH      = 4,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic [CW-1:0]    count,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic                  r_valid [DEPTH];
   logic [WIDTH-1:0]      r_data  [DEPTH];
   logic [DELAY_BITS-1:0] r_cnt   [DEPTH];
   logic [AW-1:0]         r_wp;
   logic [AW-1:0]         r_rp;
   logic [CW-1:0]         r_count;
   logic                  r_overflow;
   logic                  w_accept;

   // ready looks only at the registered count, never at this cycle's done
   assign ready    = reset_n && (r_count < CW'(DEPTH));
   assign done     = reset_n && r_valid[r_rp] && (r_cnt[r_rp] == '0);
   assign out      = done ? r_data[r_rp] : '0;
   assign count    = r_count;
   assign overflow = r_overflow;
   assign w_accept = start && ready;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
         end
         r_wp       <= '0;
         r_rp       <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_accept && (r_wp == AW'(i))) begin
               r_valid[i] <= 1'b1;
               r_data[i]  <= in;
               r_cnt[i]   <= in[DELAY_BITS-1:0];
            end else begin
               if (done && (r_rp == AW'(i))) begin
                  r_valid[i] <= 1'b0;
               end
               if (r_valid[i] && (r_cnt[i] != '0)) begin
                  r_cnt[i] <= r_cnt[i] - DELAY_BITS'(1);
               end
            end
         end
         if (w_accept) begin
            r_wp <= r_wp + AW'(1);
         end
         if (done) begin
            r_rp <= r_rp + AW'(1);
         end
         case ({w_accept, done})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (start && !ready) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_multi_data_queue.sv
// tb/tb_multi_data_queue.sv - directed bench for multi_data_queue
// A completion-time model (max of own deadline and predecessor + 1) is checked every cycle.
module tb_multi_data_queue;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clock = 1'b0;
   logic             reset_n;
   logic             start;
   logic [WIDTH-1:0] in;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] out;
   logic [CW-1:0]    count;
   logic             overflow;

   multi_data_queue #(.WIDTH(WIDTH), .DELAY_BITS(2), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .in(in),
      .ready(ready), .done(done), .out(out), .count(count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               comp;
   } ent_t;

   ent_t             mq[$];
   int               cyc = 0;
   int               last_comp = -100;
   bit               m_ovf = 0;
   bit               armed = 0;
   bit               log_en = 0;
   logic [WIDTH-1:0] got[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model update at each edge: completion cycle = max(accept + 1 + d, previous completion + 1)
   initial forever begin
      @(posedge clock);
      if (!reset_n) begin
         mq.delete();
         m_ovf     = 0;
         last_comp = -100;
         armed     = 1;
      end else if (armed) begin
         bit m_rdy;
         bit m_done;
         int c;
         m_rdy  = mq.size() < DEPTH;
         m_done = (mq.size() > 0) && (mq[0].comp == cyc);
         if (start && !m_rdy) m_ovf = 1;
         if (m_done) void'(mq.pop_front());
         if (start && m_rdy) begin
            c = cyc + 1 + int'(in[1:0]);
            if (c < last_comp + 1) c = last_comp + 1;
            last_comp = c;
            mq.push_back('{in, c});
         end
      end
      cyc++;
   end

   initial forever begin
      @(negedge clock);
      if (armed) begin
         logic             e_done;
         logic [WIDTH-1:0] e_out;
         e_done = reset_n && (mq.size() > 0) && (mq[0].comp == cyc);
         e_out  = e_done ? mq[0].data : '0;
         chk("m_ready", 32'(ready), 32'(reset_n && (mq.size() < DEPTH)));
         chk("m_done", 32'(done), 32'(e_done));
         chk("m_out", out, e_out);
         chk("m_count", 32'(count), 32'(mq.size()));
         chk("m_overflow", 32'(overflow), 32'(m_ovf));
         if (log_en && done) got.push_back(out);
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      start   = 1'b0;
      in      = '0;
      tick;
      tick;
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int guard;

      // Single request, d = 3
      do_reset;
      start = 1'b1;
      in    = 32'h3;
      #3;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      tick;
      start = 1'b0;
      in    = '0;
      for (int k = 1; k <= 6; k++) begin
         #3;
         chk("single_done", 32'(done), 32'(k == 4));
         chk("single_out", out, (k == 4) ? 32'h3 : 32'h0);
         if (k == 1) chk("single_count1", 32'(count), 32'd1);
         if (k == 5) chk("single_count0", 32'(count), 32'd0);
         tick;
      end

      // Younger finished entry waits for the head
      do_reset;
      start = 1'b1;
      in    = 32'hA3;
      tick;
      in    = 32'hB0;
      tick;
      start = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         #3;
         chk("order_done", 32'(done), 32'(k == 4 || k == 5));
         chk("order_out", out, (k == 4) ? 32'hA3 : (k == 5) ? 32'hB0 : 32'h0);
         tick;
      end

      // Fill to full, refused start in the cycle the head completes
      do_reset;
      for (int k = 0; k < 4; k++) begin
         start = 1'b1;
         in    = 32'((k + 1) * 16 + 3);
         tick;
      end
      in = 32'h53;
      #3;
      chk("full_ready", 32'(ready), 32'd0);
      chk("full_count", 32'(count), 32'd4);
      chk("full_out4", out, 32'h13);
      tick;
      start = 1'b0;
      for (int k = 5; k <= 8; k++) begin
         #3;
         if (k == 5) chk("full_overflow", 32'(overflow), 32'd1);
         if (k == 5) chk("full_out5", out, 32'h23);
         if (k == 6) chk("full_out6", out, 32'h33);
         if (k == 7) chk("full_out7", out, 32'h43);
         if (k == 8) chk("full_nostore", 32'(done), 32'd0);
         if (k == 8) chk("full_empty", 32'(count), 32'd0);
         tick;
      end

      // Sustained streaming with d = 0
      do_reset;
      start = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in = 32'(k * 4);
         if (k >= 1) begin
            #3;
            chk("stream_done", 32'(done), 32'd1);
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_ready", 32'(ready), 32'd1);
            chk("stream_out", out, 32'((k - 1) * 4));
         end
         tick;
      end
      start = 1'b0;
      #3;
      chk("stream_last", out, 32'(19 * 4));
      tick;

      // Wrap-around: data 0..9, delay = data[1:0]
      do_reset;
      got.delete();
      log_en = 1;
      for (int k = 0; k < 10; k++) begin
         start = 1'b0;
         in    = 32'(k);
         guard = 0;
         while (!ready && guard < 50) begin
            tick;
            guard++;
         end
         chk("wrap_ready_wait", 32'(guard < 50), 32'd1);
         start = 1'b1;
         tick;
      end
      start = 1'b0;
      guard = 0;
      while (got.size() < 10 && guard < 60) begin
         tick;
         guard++;
      end
      #3;
      log_en = 0;
      chk("wrap_total", 32'(got.size()), 32'd10);
      for (int i = 0; i < got.size() && i < 10; i++) begin
         chk("wrap_data", got[i], 32'(i));
      end
      tick;

      // Reset mid-operation discards in-flight requests
      do_reset;
      start = 1'b1;
      in    = 32'h3;
      tick;
      in    = 32'h13;
      tick;
      in      = 32'h23;
      reset_n = 1'b0;
      #3;
      chk("midrst_ready", 32'(ready), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      tick;
      reset_n = 1'b1;
      start   = 1'b0;
      #3;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_ready1", 32'(ready), 32'd1);
      chk("midrst_overflow", 32'(overflow), 32'd0);
      tick;
      for (int k = 0; k < 5; k++) begin
         #3;
         chk("midrst_nodone", 32'(done), 32'd0);
         tick;
      end
      start = 1'b1;
      in    = 32'h5;
      tick;
      start = 1'b0;
      #3;
      chk("post_done1", 32'(done), 32'd0);
      tick;
      #3;
      chk("post_done2", 32'(done), 32'd1);
      chk("post_out2", out, 32'h5);
      tick;
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
